johnson_phase_decoder: RTL and testbench

//  Downstream consumer of the 5-stage twisted-ring (Johnson) counter. Samples the

---
 rtl/johnson_phase_decoder.sv | 148 ++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Decodes a twisted-ring (Johnson) counter state into a phase index and one-hot bus,
// checks the ring sequence, counts revolutions and tracks lock/loss of lock.
module johnson_phase_decoder #(
    parameter int unsigned N         = 5,
    parameter int unsigned REV_W     = 8,
    parameter int unsigned ERR_LIMIT = 3,
    localparam int unsigned IW       = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic [N-1:0]     q_in,
    input  logic             clr_err,
    output logic [2*N-1:0]   phase,
    output logic [IW-1:0]    idx,
    output logic             valid,
    output logic             wrap,
    output logic [REV_W-1:0] rev_cnt,
    output logic             illegal,
    output logic             seq_err,
    output logic             lost
);

    localparam int unsigned   EW      = $clog2(ERR_LIMIT + 1);
    localparam logic [IW-1:0] LastIdx = IW'(2 * N - 1);

    typedef enum logic [1:0] {StHunt, StLock, StLost} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [REV_W-1:0]   rev_q, rev_d;
    logic [EW-1:0]      err_q, err_d;
    logic               wrap_q, wrap_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;

    logic               code_legal;
    logic [IW-1:0]      code_idx;
    logic [IW-1:0]      expect_idx;

    // Phase k: k <= N has the top k bits set, k > N has the low 2N-k bits set.
    function automatic logic [N-1:0] johnson_code(input int unsigned k);
        logic [N-1:0] c;
        c = '0;
        for (int unsigned b = 0; b < N; b++) begin
            if (k <= N) c[b] = (b + k >= N);
            else        c[b] = (b + k < 2 * N);
        end
        return c;
    endfunction

    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int unsigned k = 0; k < 2 * N; k++) begin
            if (q_in == johnson_code(k)) begin
                code_legal = 1'b1;
                code_idx   = IW'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rev_d      = rev_q;
        err_d      = err_q;
        wrap_d     = 1'b0;
        illegal_d  = 1'b0;
        seq_err_d  = 1'b0;
        expect_idx = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

        // clr_err takes priority and discards any sample in the same cycle.
        if (clr_err) begin
            err_d = '0;
            if (state_q == StLost) state_d = StHunt;
        end else if (en) begin
            unique case (state_q)
                StHunt: begin
                    if (code_legal) begin
                        state_d = StLock;
                        idx_d   = code_idx;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                StLock: begin
                    if (!code_legal) begin
                        illegal_d = 1'b1;
                        err_d     = err_q + 1'b1;
                    end else if (code_idx == expect_idx) begin
                        idx_d = code_idx;
                        err_d = '0;
                        if (idx_q == LastIdx) begin
                            wrap_d = 1'b1;
                            rev_d  = rev_q + 1'b1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        idx_d     = code_idx;
                        err_d     = err_q + 1'b1;
                    end
                    if (err_d >= EW'(ERR_LIMIT)) state_d = StLost;
                end
                StLost: begin
                    illegal_d = !code_legal;
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state_q   <= StHunt;
            idx_q     <= '0;
            rev_q     <= '0;
            err_q     <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rev_q     <= rev_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_comb begin
        phase = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            phase[i] = (state_q == StLock) && (idx_q == IW'(i));
        end
    end

    assign idx     = idx_q;
    assign valid   = (state_q == StLock);
    assign lost    = (state_q == StLost);
    assign wrap    = wrap_q;
    assign rev_cnt = rev_q;
    assign illegal = illegal_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder: default instance plus a REV_W=2,
// ERR_LIMIT=1 instance for revolution wrap and single-error loss of lock.
module tb_johnson_phase_decoder;

    logic       clk;
    logic       preset;
    logic       en, clr_err;
    logic [4:0] q_in;
    logic [9:0] phase;
    logic [3:0] idx;
    logic       valid, wrap, illegal, seq_err, lost;
    logic [7:0] rev_cnt;

    logic       en2, clr_err2;
    logic [4:0] q_in2;
    logic [9:0] phase2;
    logic [3:0] idx2;
    logic       valid2, wrap2, illegal2, seq_err2, lost2;
    logic [1:0] rev_cnt2;

    logic [4:0] codes [0:9];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         wraps;

    johnson_phase_decoder dut (
        .clk(clk), .preset(preset), .en(en), .q_in(q_in), .clr_err(clr_err),
        .phase(phase), .idx(idx), .valid(valid), .wrap(wrap), .rev_cnt(rev_cnt),
        .illegal(illegal), .seq_err(seq_err), .lost(lost)
    );

    johnson_phase_decoder #(.N(5), .REV_W(2), .ERR_LIMIT(1)) dut2 (
        .clk(clk), .preset(preset), .en(en2), .q_in(q_in2), .clr_err(clr_err2),
        .phase(phase2), .idx(idx2), .valid(valid2), .wrap(wrap2), .rev_cnt(rev_cnt2),
        .illegal(illegal2), .seq_err(seq_err2), .lost(lost2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic step(input logic e, input logic [4:0] q, input logic c);
        en = e; q_in = q; clr_err = c;
        @(posedge clk);
        #1;
        en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic step2(input logic [4:0] q);
        en2 = 1'b1; q_in2 = q;
        @(posedge clk);
        #1;
        en2 = 1'b0;
    endtask

    initial begin
        codes = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
                  5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};
        en = 0; clr_err = 0; q_in = 0;
        en2 = 0; clr_err2 = 0; q_in2 = 0;
        preset = 1'b1;
        #3;
        chk("rst_valid", valid, 0);
        chk("rst_phase", phase, 0);
        chk("rst_idx", idx, 0);
        chk("rst_rev", rev_cnt, 0);
        chk("rst_lost", lost, 0);
        chk("rst_pulses", {wrap, illegal, seq_err}, 0);
        @(posedge clk);
        #1;
        preset = 1'b0;

        // 1: two full revolutions plus the first phase again
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 10; k++) begin
                step(1, codes[k], 0);
                chk("t1_valid", valid, 1);
                chk("t1_idx", idx, k);
                chk("t1_phase", phase, 32'd1 << k);
                chk("t1_wrap", wrap, (r == 1 && k == 0) ? 1 : 0);
                chk("t1_rev", rev_cnt, r);
                chk("t1_errs", {illegal, seq_err, lost}, 0);
            end
        end
        step(1, codes[0], 0);
        chk("t1_final_wrap", wrap, 1);
        chk("t1_final_rev", rev_cnt, 2);
        chk("t1_final_idx", idx, 0);
        step(0, 5'b10101, 0);
        chk("t1_hold_idx", idx, 0);
        chk("t1_hold_pulses", {wrap, illegal, seq_err}, 0);
        chk("t1_hold_rev", rev_cnt, 2);

        // 2: illegal code in HUNT, then lock on 11000
        preset = 1'b1;
        #1;
        preset = 1'b0;
        chk("t2_rst_valid", valid, 0);
        step(1, 5'b11011, 0);
        chk("t2_illegal", illegal, 1);
        chk("t2_valid0", valid, 0);
        step(1, 5'b11000, 0);
        chk("t2_valid1", valid, 1);
        chk("t2_idx", idx, 2);
        chk("t2_phase", phase, 10'b0000000100);
        chk("t2_no_illegal", illegal, 0);

        // 3: sequence break resyncs, a good step clears the error count
        step(1, 5'b11100, 0);
        chk("t3_idx3", idx, 3);
        step(1, 5'b11111, 0);
        chk("t3_seq_err", seq_err, 1);
        chk("t3_idx5", idx, 5);
        chk("t3_no_wrap", wrap, 0);
        step(1, 5'b01111, 0);
        chk("t3_idx6", idx, 6);
        chk("t3_seq_clear", seq_err, 0);
        step(1, 5'b10101, 0);
        step(1, 5'b10101, 0);
        chk("t3_errcnt_cleared", valid, 1);
        chk("t3_illegal_hold_idx", idx, 6);
        step(1, 5'b00111, 0);
        chk("t3_idx7", idx, 7);

        // 4: three illegal samples lose lock, clr_err+en returns to HUNT
        step(1, 5'b10101, 0);
        chk("t4_ill1", illegal, 1);
        step(1, 5'b10101, 0);
        chk("t4_ill2", illegal, 1);
        chk("t4_still_lock", valid, 1);
        step(1, 5'b10101, 0);
        chk("t4_ill3", illegal, 1);
        chk("t4_lost", lost, 1);
        chk("t4_valid0", valid, 0);
        chk("t4_phase0", phase, 0);
        chk("t4_idx_hold", idx, 7);
        step(1, 5'b00011, 0);
        chk("t4_lost_ignores", {lost, illegal, seq_err, idx}, {3'b100, 4'd7});
        step(1, 5'b01010, 0);
        chk("t4_lost_illegal", illegal, 1);
        step(1, 5'b10000, 1);
        chk("t4_clr_lost", lost, 0);
        chk("t4_clr_discard", valid, 0);
        step(1, 5'b10000, 0);
        chk("t4_relock", {valid, idx}, {1'b1, 4'd1});

        // 5: five revolutions, stop at idx 7, then async preset
        for (int p = 0; p < 5; p++) begin
            for (int k = 2; k < 10; k++) step(1, codes[k], 0);
            step(1, codes[0], 0);
            step(1, codes[1], 0);
        end
        for (int k = 2; k < 8; k++) step(1, codes[k], 0);
        chk("t5_idx7", idx, 7);
        chk("t5_rev5", rev_cnt, 5);
        #2;
        preset = 1'b1;
        #1;
        chk("t5_async_idx", idx, 0);
        chk("t5_async_rev", rev_cnt, 0);
        chk("t5_async_flags", {valid, lost, wrap, illegal, seq_err}, 0);
        chk("t5_async_phase", phase, 0);
        @(posedge clk);
        #1;
        preset = 1'b0;
        step(1, 5'b00011, 0);
        chk("t5_relock", {valid, idx}, {1'b1, 4'd8});
        chk("t5_relock_phase", phase, 10'b0100000000);

        // 6: REV_W=2 revolution counter wraps; ERR_LIMIT=1 loses lock at once
        wraps = 0;
        step2(codes[0]);
        chk("t6_lock", valid2, 1);
        for (int r = 1; r <= 4; r++) begin
            for (int k = 1; k < 10; k++) begin
                step2(codes[k]);
                wraps += int'(wrap2);
            end
            step2(codes[0]);
            wraps += int'(wrap2);
            chk("t6_wrap", wrap2, 1);
            chk("t6_rev", rev_cnt2, r % 4);
        end
        chk("t6_wrap_count", wraps, 4);
        step2(5'b10101);
        chk("t6_lim1_lost", {lost2, illegal2, valid2}, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
